// File: rtl/wide_to_narrow_fifo_if.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_fifo_if
// Handshake bundle for the wide-to-narrow width-converting FIFO.
//   flush     : synchronous clear request (producer side)
//   wr_valid  : wide word offered           wr_ready : FIFO accepts wide word
//   wr_data   : wide word, RD_WIDTH*RATIO bits
//   rd_valid  : rd_data holds a narrow word rd_ready : consumer takes rd_data
//   rd_data   : narrow word, RD_WIDTH bits
//   wr_count  : wide words held in storage (log2(DEPTH)+1 bits)
// Modports: master = the environment driving the FIFO, slave = the FIFO.
// -----------------------------------------------------------------------------
interface wide_to_narrow_fifo_if #(
   parameter int RD_WIDTH = 16,
   parameter int RATIO    = 4,
   parameter int DEPTH    = 128
);
   localparam int WR_WIDTH = RD_WIDTH * RATIO;
   localparam int CNT_W    = $clog2(DEPTH) + 1;

   logic                flush;
   logic                wr_valid;
   logic                wr_ready;
   logic [WR_WIDTH-1:0] wr_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [RD_WIDTH-1:0] rd_data;
   logic [CNT_W-1:0]    wr_count;

   modport master (
      output flush, wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data, wr_count
   );

   modport slave (
      input  flush, wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data, wr_count
   );
endinterface

// File: rtl/wide_to_narrow_fifo.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_fifo
// Single-clock FIFO that stores wide words (RATIO lanes of RD_WIDTH bits) and
// emits them one narrow lane at a time through a one-word output register.
// Ports:
//   clk    : clock, all logic on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : wide_to_narrow_fifo_if.slave (flush, write port, read port,
//            occupancy count)
// Parameters: RD_WIDTH, RATIO (power of two), DEPTH (power of two),
//   MSB_FIRST (0 = lane 0 first, 1 = top lane first).
// -----------------------------------------------------------------------------
module wide_to_narrow_fifo #(
   parameter int RD_WIDTH  = 16,
   parameter int RATIO     = 4,
   parameter int DEPTH     = 128,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                 clk,
   input logic                 resetn,
   wide_to_narrow_fifo_if.slave bus
);
   localparam int WW = RD_WIDTH * RATIO;
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(RATIO);
   localparam int CW = AW + 1;

   // Storage: no reset so it maps onto block RAM.
   logic [WW-1:0] mem [DEPTH];

   logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
   logic [SW-1:0]       sel_q,      sel_d;
   logic [CW-1:0]       count_q,    count_d;
   logic                rd_valid_q, rd_valid_d;
   logic [RD_WIDTH-1:0] rd_data_q,  rd_data_d;

   logic                wr_fire;
   logic                load;
   logic                free;
   logic [SW-1:0]       lane_idx;
   logic [WW-1:0]       rd_word;
   logic [RD_WIDTH-1:0] lanes [RATIO];

   assign bus.wr_ready = resetn && !bus.flush && (count_q != CW'(DEPTH));
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.wr_count = count_q;

   assign wr_fire = bus.wr_valid && bus.wr_ready;

   // The output register takes a lane whenever storage holds a word and the
   // register is empty or being popped on this edge.
   assign load = !bus.flush && (count_q != '0) && (!rd_valid_q || bus.rd_ready);
   assign free = load && (sel_q == SW'(RATIO - 1));

   // RATIO is a power of two, so RATIO-1-sel is simply the bitwise inverse.
   assign lane_idx = MSB_FIRST ? ~sel_q : sel_q;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   // The array word at the read pointer feeds rd_data_q directly, which acts
   // as the registered read stage of the RAM.
   assign rd_word = mem[rd_ptr_q];

   for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lanes[gi] = rd_word[gi*RD_WIDTH +: RD_WIDTH];
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sel_d      = sel_q;
      count_d    = count_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;

      if (bus.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         sel_d      = '0;
         count_d    = '0;
         rd_valid_d = 1'b0;
         rd_data_d  = '0;
      end else begin
         if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end

         if (load) begin
            rd_data_d  = lanes[lane_idx];
            rd_valid_d = 1'b1;
            sel_d      = sel_q + SW'(1);
            if (free) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
         end else if (rd_valid_q && bus.rd_ready) begin
            rd_valid_d = 1'b0;
         end

         // A word stays counted until its last lane has been loaded.
         case ({wr_fire, free})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sel_q      <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sel_q      <= sel_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end
endmodule

// File: doc/wide_to_narrow_fifo.md
# wide_to_narrow_fifo

Single-clock, parametrised width-converting FIFO: accepts wide words (RATIO narrow lanes) on a valid/ready write port and emits them as a stream of narrow words on a valid/ready read port.
- Sits between the acquisition packer, which produces 64-bit sample groups, and the 16-bit serial/readout path.
- Replaces the fixed 64→16 block-RAM buffer with configurable width, depth and lane order, plus flow control, occupancy reporting and flush.

## Interface
Parameters:
- RD_WIDTH, 16, narrow (read) word width in bits, ≥1
- RATIO, 4, narrow words per wide word, power of two, ≥2
- DEPTH, 128, wide-word capacity, power of two, ≥2
- MSB_FIRST, 0, 0 = lane 0 (wr_data[RD_WIDTH-1:0]) emitted first; 1 = top lane emitted first

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- wr_valid  in  1  wide word offered
- wr_ready  out  1  FIFO can accept a wide word
- wr_data  in  RD_WIDTH*RATIO  wide word
- rd_valid  out  1  rd_data holds a valid narrow word
- rd_ready  in  1  consumer takes rd_data
- rd_data  out  RD_WIDTH  narrow word, registered
- wr_count  out  log2(DEPTH)+1  wide words held in storage, including a partially consumed word

## Operation
- Storage: DEPTH × (RD_WIDTH*RATIO) array, not reset; inferred as block RAM with registered read.
- Pointers: write and read pointers of log2(DEPTH) bits, wrapping naturally at DEPTH. Lane select `sel` is log2(RATIO) bits.
- Write handshake: a word is accepted on an edge where wr_valid && wr_ready.
  - wr_ready = resetn && !flush && (wr_count != DEPTH).
  - There is no write bypass when full. A same-cycle free does not make wr_ready high.
- Output stage: a one-word register (rd_data/rd_valid).
  - It loads when storage is non-empty and either rd_valid=0 or (rd_valid && rd_ready).
  - Lane loaded: index sel when MSB_FIRST=0, RATIO-1-sel when MSB_FIRST=1.
  - Each load increments sel. When sel wraps from RATIO-1 to 0, the read pointer advances and the wide word is freed (wr_count decrements).
- Pop: rd_valid && rd_ready. If no load occurs on the same edge, rd_valid clears.
- rd_data changes only on a load; it holds its value while rd_valid && !rd_ready.
- wr_count update: +1 on accept, −1 on free, unchanged when both occur on the same edge.
- Flush (sync, 1 cycle):
  - Clears pointers, sel, wr_count, rd_valid and rd_data.
  - A write offered in the flush cycle is dropped (wr_ready=0).
- Reset (async assert, sync-released):
  - wr_count=0, rd_valid=0, rd_data=0, sel=0, pointers=0.
  - wr_ready=0 while resetn=0 and 1 on the first cycle after release.
  - Reset mid-stream discards all data, including a partially emitted wide word.

## Timing
- Write-to-read latency: a word accepted at edge E shows wr_count≥1 after E. Its first lane is loaded at edge E+1, so rd_valid=1 in the cycle after E+1. This holds when storage and the output register were empty.
- Throughput: one narrow word per clock with rd_ready held high. One wide word is drained every RATIO clocks with no bubbles between wide words.
- Sustained rate: a writer may push one word per RATIO clocks indefinitely without wr_ready dropping.
- Full: wr_count==DEPTH forces wr_ready=0. It returns to 1 in the cycle after the edge that frees the last lane of the oldest word.
- Empty: storage empty and output popped gives rd_valid=0 the next cycle. No read from the array occurs while empty.
- Read stall: with rd_ready=0, sel and pointers hold. rd_data and rd_valid are stable, a requirement for the downstream serializer.
- Capacity: the output register does not add capacity. A partially consumed word counts as one full word until its last lane is loaded.

## Test plan
- Reset/idle: hold resetn=0 for 3 cycles, release. Required: rd_valid=0, rd_data=0, wr_count=0, wr_ready=0 during reset and 1 after release.
- Single word, defaults: write 64'h4444_3333_2222_1111, rd_ready=1. Required: rd_data sequence 1111, 2222, 3333, 4444 on consecutive cycles, first one cycle after the accept edge; wr_count 1→0 on the fourth load.
- MSB_FIRST=1: same word. Required: 4444, 3333, 2222, 1111.
- Fill/wrap: rd_ready=0, write 128 words with an incrementing pattern. Required: wr_ready=0 at wr_count=128 and a 129th offer is not accepted. Then drain with rd_ready=1: 512 narrow words in order, pointer wrap invisible, and further writes accepted after the first word is freed.
- Backpressure: random rd_ready (50%) and random wr_valid on a 1000-word stream. Required: scoreboard matches exactly; rd_data stable while stalled; no loss or duplication.
- Flush and reset mid-word: after 2 of 4 lanes are read, assert flush. Required: next cycle rd_valid=0, wr_count=0, and a new write emits its lane 0 first. Repeat with resetn pulsed low asynchronously; same result.
